// File: rtl/vscale_htif_pcr_bridge_pkg.sv
// Shared widths, command layout and FSM encoding for the HTIF PCR bridge.
package vscale_htif_pcr_bridge_pkg;

  localparam int unsigned CSR_ADDR_WIDTH              = 12;
  localparam int unsigned HTIF_PCR_WIDTH              = 64;
  localparam int unsigned HTIF_CMD_WIDTH              = 1 + CSR_ADDR_WIDTH + HTIF_PCR_WIDTH;
  localparam int unsigned HTIF_TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } bridge_state_t;

  typedef struct packed {
    logic                      rw;
    logic [CSR_ADDR_WIDTH-1:0] addr;
    logic [HTIF_PCR_WIDTH-1:0] data;
  } htif_cmd_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vscale_htif_pcr_bridge_if.sv
// Host command/response and PCR request/response channels of the bridge.
interface vscale_htif_pcr_bridge_if;
  import vscale_htif_pcr_bridge_pkg::*;

  logic                      host_cmd_valid;
  logic                      host_cmd_ready;
  logic                      host_cmd_rw;
  logic [CSR_ADDR_WIDTH-1:0] host_cmd_addr;
  logic [HTIF_PCR_WIDTH-1:0] host_cmd_data;
  logic                      host_resp_valid;
  logic                      host_resp_ready;
  logic [HTIF_PCR_WIDTH-1:0] host_resp_data;
  logic                      host_resp_timeout;
  logic                      pcr_req_valid;
  logic                      pcr_req_ready;
  logic                      pcr_req_rw;
  logic [CSR_ADDR_WIDTH-1:0] pcr_req_addr;
  logic [HTIF_PCR_WIDTH-1:0] pcr_req_data;
  logic                      pcr_resp_valid;
  logic                      pcr_resp_ready;
  logic [HTIF_PCR_WIDTH-1:0] pcr_resp_data;

  modport slave (
    input  host_cmd_valid, host_cmd_rw, host_cmd_addr, host_cmd_data, host_resp_ready,
    input  pcr_req_ready, pcr_resp_valid, pcr_resp_data,
    output host_cmd_ready, host_resp_valid, host_resp_data, host_resp_timeout,
    output pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_resp_ready
  );

  modport master (
    output host_cmd_valid, host_cmd_rw, host_cmd_addr, host_cmd_data, host_resp_ready,
    output pcr_req_ready, pcr_resp_valid, pcr_resp_data,
    input  host_cmd_ready, host_resp_valid, host_resp_data, host_resp_timeout,
    input  pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_resp_ready
  );

endinterface

// File: rtl/vscale_htif_cmd_fifo.sv
// Synchronous power-of-two FIFO with async active-low reset and full/empty/count.
module vscale_htif_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vscale_htif_pcr_bridge.sv
// Host-side HTIF PCR front end: queues CSR commands, issues one at a time, returns responses with a watchdog.
module vscale_htif_pcr_bridge
  import vscale_htif_pcr_bridge_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = HTIF_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  vscale_htif_pcr_bridge_if.slave  bus,
  output logic                     busy,
  output logic [7:0]               stale_drops
);
  localparam int unsigned CNT_W    = $clog2(CMD_DEPTH) + 1;
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES) - 32'd1;

  bridge_state_t             state;
  htif_cmd_t                 push_cmd;
  htif_cmd_t                 head;
  logic                      full;
  logic                      empty;
  logic [CNT_W-1:0]          count;
  logic [31:0]               watchdog;
  logic                      req_valid_q;
  logic                      resp_valid_q;
  logic                      resp_timeout_q;
  logic [HTIF_PCR_WIDTH-1:0] resp_data_q;

  assign push_cmd = {bus.host_cmd_rw, bus.host_cmd_addr, bus.host_cmd_data};

  vscale_htif_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (HTIF_CMD_WIDTH)
  ) cmd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (bus.host_cmd_valid),
    .push_data (push_cmd),
    .pop       (req_valid_q && bus.pcr_req_ready),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign bus.host_cmd_ready    = !full;
  assign bus.pcr_req_valid     = req_valid_q;
  assign bus.pcr_req_rw        = head.rw;
  assign bus.pcr_req_addr      = head.addr;
  assign bus.pcr_req_data      = head.data;
  assign bus.pcr_resp_ready    = 1'b1;
  assign bus.host_resp_valid   = resp_valid_q;
  assign bus.host_resp_data    = resp_data_q;
  assign bus.host_resp_timeout = resp_timeout_q;
  assign busy                  = (count != '0) || (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      watchdog       <= '0;
      req_valid_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= '0;
      stale_drops    <= '0;
    end else begin
      // Responses can only be matched to a request while waiting; anything else is a late leftover.
      if (bus.pcr_resp_valid && (state != ST_WAIT)) stale_drops <= sat_inc8(stale_drops);

      case (state)
        ST_IDLE: begin
          if (!empty) begin
            req_valid_q <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.pcr_req_ready) begin
            req_valid_q <= 1'b0;
            watchdog    <= '0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          watchdog <= watchdog + 32'd1;
          if (bus.pcr_resp_valid) begin
            resp_data_q    <= bus.pcr_resp_data;
            resp_timeout_q <= 1'b0;
            resp_valid_q   <= 1'b1;
            state          <= ST_RESP;
          end else if (WD_EN && (watchdog == WD_LIMIT)) begin
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b1;
            resp_valid_q   <= 1'b1;
            state          <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.host_resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_htif_pcr_bridge.sv
// Directed bench for vscale_htif_pcr_bridge with CMD_DEPTH=4, TIMEOUT_CYCLES=8.
module tb_vscale_htif_pcr_bridge;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       busy;
  logic [7:0] stale_drops;
  int         checks   = 0;
  int         failures = 0;

  vscale_htif_pcr_bridge_if bus ();

  vscale_htif_pcr_bridge #(
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .stale_drops (stale_drops)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic rw, input logic [11:0] addr, input logic [63:0] data);
    bus.host_cmd_valid = 1'b1;
    bus.host_cmd_rw    = rw;
    bus.host_cmd_addr  = addr;
    bus.host_cmd_data  = data;
    for (int i = 0; i < 50 && !bus.host_cmd_ready; i++) tick();
    check("push_ready", 64'(bus.host_cmd_ready), 64'd1);
    tick();
    bus.host_cmd_valid = 1'b0;
  endtask

  task automatic fire_req(input logic rw, input logic [11:0] addr, input logic [63:0] data);
    for (int i = 0; i < 20 && !bus.pcr_req_valid; i++) tick();
    check("req_valid", 64'(bus.pcr_req_valid), 64'd1);
    check("req_rw", 64'(bus.pcr_req_rw), 64'(rw));
    check("req_addr", 64'(bus.pcr_req_addr), 64'(addr));
    check("req_data", bus.pcr_req_data, data);
    bus.pcr_req_ready = 1'b1;
    tick();
    bus.pcr_req_ready = 1'b0;
    check("req_drop", 64'(bus.pcr_req_valid), 64'd0);
  endtask

  task automatic respond(input logic [63:0] d);
    bus.pcr_resp_valid = 1'b1;
    bus.pcr_resp_data  = d;
    tick();
    bus.pcr_resp_valid = 1'b0;
    check("resp_valid", 64'(bus.host_resp_valid), 64'd1);
    check("resp_data", bus.host_resp_data, d);
    check("resp_tmo", 64'(bus.host_resp_timeout), 64'd0);
  endtask

  task automatic consume;
    bus.host_resp_ready = 1'b1;
    tick();
    bus.host_resp_ready = 1'b0;
    check("resp_done", 64'(bus.host_resp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic        rw;
    logic [63:0] d;
    reset_n             = 1'b0;
    bus.host_cmd_valid  = 1'b0;
    bus.host_cmd_rw     = 1'b0;
    bus.host_cmd_addr   = '0;
    bus.host_cmd_data   = '0;
    bus.host_resp_ready = 1'b0;
    bus.pcr_req_ready   = 1'b0;
    bus.pcr_resp_valid  = 1'b0;
    bus.pcr_resp_data   = '0;

    #2;
    check("rst_req_valid", 64'(bus.pcr_req_valid), 64'd0);
    check("rst_resp_valid", 64'(bus.host_resp_valid), 64'd0);
    check("rst_resp_data", bus.host_resp_data, 64'd0);
    check("rst_resp_tmo", 64'(bus.host_resp_timeout), 64'd0);
    check("rst_cmd_ready", 64'(bus.host_cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stale", 64'(stale_drops), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Basic write with fixed latencies
    bus.pcr_req_ready  = 1'b1;
    bus.host_cmd_valid = 1'b1;
    bus.host_cmd_rw    = 1'b1;
    bus.host_cmd_addr  = 12'h780;
    bus.host_cmd_data  = 64'h1234;
    tick();
    bus.host_cmd_valid = 1'b0;
    check("t1_cyc1_req", 64'(bus.pcr_req_valid), 64'd0);
    check("t1_cyc1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_cyc2_req", 64'(bus.pcr_req_valid), 64'd1);
    check("t1_addr", 64'(bus.pcr_req_addr), 64'h780);
    check("t1_rw", 64'(bus.pcr_req_rw), 64'd1);
    check("t1_data", bus.pcr_req_data, 64'h1234);
    tick();
    bus.pcr_req_ready = 1'b0;
    check("t1_fired", 64'(bus.pcr_req_valid), 64'd0);
    tick();
    tick();
    check("t1_no_early_resp", 64'(bus.host_resp_valid), 64'd0);
    respond(64'hCAFE);
    consume();
    check("t1_idle_busy", 64'(busy), 64'd0);

    // Fill the FIFO with the CSR port stalled
    for (int i = 0; i < 5; i++) begin
      bus.host_cmd_valid = 1'b1;
      bus.host_cmd_rw    = i[0];
      bus.host_cmd_addr  = 12'h100 + 12'(i);
      bus.host_cmd_data  = 64'(i) * 64'h11;
      check("t2_cmd_ready", 64'(bus.host_cmd_ready), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) tick();
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_held_off", 64'(bus.host_cmd_ready), 64'd0);
    end
    check("t2_head_valid", 64'(bus.pcr_req_valid), 64'd1);
    check("t2_head_addr", 64'(bus.pcr_req_addr), 64'h100);
    bus.pcr_req_ready = 1'b1;
    tick();
    bus.pcr_req_ready = 1'b0;
    check("t2_ready_after_pop", 64'(bus.host_cmd_ready), 64'd1);
    tick();
    bus.host_cmd_valid = 1'b0;
    check("t2_full_again", 64'(bus.host_cmd_ready), 64'd0);
    respond(64'hA0);
    consume();
    for (int i = 1; i < 5; i++) begin
      rw = i[0];
      d  = 64'(i) * 64'h11;
      fire_req(rw, 12'h100 + 12'(i), d);
      respond(64'hA0 + 64'(i));
      consume();
    end
    check("t2_drained", 64'(busy), 64'd0);

    // Watchdog expiry, then a late response counted as stale
    push_cmd(1'b0, 12'h300, 64'h0);
    fire_req(1'b0, 12'h300, 64'h0);
    for (int k = 0; k < 7; k++) tick();
    check("t3_before_limit", 64'(bus.host_resp_valid), 64'd0);
    tick();
    check("t3_tmo_valid", 64'(bus.host_resp_valid), 64'd1);
    check("t3_tmo_flag", 64'(bus.host_resp_timeout), 64'd1);
    check("t3_tmo_data", bus.host_resp_data, 64'd0);
    consume();
    bus.pcr_resp_valid = 1'b1;
    bus.pcr_resp_data  = 64'h55;
    tick();
    bus.pcr_resp_valid = 1'b0;
    check("t3_stale", 64'(stale_drops), 64'd1);
    check("t3_no_resp", 64'(bus.host_resp_valid), 64'd0);
    check("t3_busy", 64'(busy), 64'd0);

    // Real response arriving on the last watchdog cycle wins
    push_cmd(1'b1, 12'h341, 64'h77);
    fire_req(1'b1, 12'h341, 64'h77);
    for (int k = 0; k < 7; k++) tick();
    check("t4_before_limit", 64'(bus.host_resp_valid), 64'd0);
    respond(64'hBEEF);
    check("t4_stale_same", 64'(stale_drops), 64'd1);
    consume();

    // Host back-pressure holds the response and blocks the next request
    push_cmd(1'b0, 12'h7A0, 64'h0);
    push_cmd(1'b0, 12'h7A1, 64'h0);
    fire_req(1'b0, 12'h7A0, 64'h0);
    respond(64'h1111);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_hold_valid", 64'(bus.host_resp_valid), 64'd1);
      check("t5_hold_data", bus.host_resp_data, 64'h1111);
      check("t5_no_req", 64'(bus.pcr_req_valid), 64'd0);
    end
    consume();
    fire_req(1'b0, 12'h7A1, 64'h0);
    respond(64'h2222);
    consume();

    // Async reset while waiting with two commands queued
    push_cmd(1'b1, 12'h010, 64'h10);
    push_cmd(1'b1, 12'h011, 64'h11);
    push_cmd(1'b1, 12'h012, 64'h12);
    fire_req(1'b1, 12'h010, 64'h10);
    check("t6_busy_pre", 64'(busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_req_valid", 64'(bus.pcr_req_valid), 64'd0);
    check("t6_resp_valid", 64'(bus.host_resp_valid), 64'd0);
    check("t6_resp_data", bus.host_resp_data, 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_stale", 64'(stale_drops), 64'd0);
    check("t6_cmd_ready", 64'(bus.host_cmd_ready), 64'd1);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t6_quiet_req", 64'(bus.pcr_req_valid), 64'd0);
      check("t6_quiet_resp", 64'(bus.host_resp_valid), 64'd0);
    end
    push_cmd(1'b1, 12'h020, 64'h99);
    fire_req(1'b1, 12'h020, 64'h99);
    respond(64'h3333);
    consume();
    check("t6_final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vscale_htif_pcr_bridge.md
Name: vscale_htif_pcr_bridge

Overview:
- Host-side front end for the core's HTIF PCR port; sits directly upstream of the CSR file and drives its htif_pcr_req_* / htif_pcr_resp_* handshakes.
- Buffers host CSR read/write commands in a small FIFO and issues them one at a time, with exactly one outstanding request.
- Returns each response to the host on a valid/ready channel, with a watchdog timeout so a hung PCR port cannot stall the host.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  core clock; all state is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- host_cmd_valid  in  1  host command offered.
- host_cmd_ready  out  1  FIFO can accept a command.
- host_cmd_rw  in  1  1 = write, 0 = read.
- host_cmd_addr  in  `CSR_ADDR_WIDTH  CSR address.
- host_cmd_data  in  `HTIF_PCR_WIDTH  write data; don't-care for reads.
- host_resp_valid  out  1  response available.
- host_resp_ready  in  1  host consumes the response.
- host_resp_data  out  `HTIF_PCR_WIDTH  read data; for writes, the PCR port's returned data.
- host_resp_timeout  out  1  response was produced by the watchdog, not the PCR port.
- pcr_req_valid  out  1  to CSR file htif_pcr_req_valid.
- pcr_req_ready  in  1  from CSR file.
- pcr_req_rw  out  1  request direction.
- pcr_req_addr  out  `CSR_ADDR_WIDTH  request address.
- pcr_req_data  out  `HTIF_PCR_WIDTH  request write data.
- pcr_resp_valid  in  1  from CSR file.
- pcr_resp_ready  out  1  to CSR file.
- pcr_resp_data  in  `HTIF_PCR_WIDTH  from CSR file.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- stale_drops  out  8  saturating count of PCR responses discarded outside WAIT.

Behaviour:
- Reset (reset_n low, async):
  - FIFO empty, FSM in IDLE, watchdog = 0, stale_drops = 0.
  - host_resp_valid = 0, host_resp_timeout = 0, host_resp_data = 0, pcr_req_valid = 0.
  - Reset mid-transaction abandons everything; no partial response is ever emitted.
- FIFO:
  - host_cmd_ready = !full.
  - A push occurs when host_cmd_valid && host_cmd_ready.
  - A pop occurs on the REQ-state fire (pcr_req_valid && pcr_req_ready).
  - A push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo CMD_DEPTH; the count is CMD_DEPTH-bit-safe (log2(CMD_DEPTH)+1 bits).
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, go to REQ.
  - REQ:
    - pcr_req_valid = 1, and pcr_req_rw/addr/data = FIFO head, combinationally.
    - On pcr_req_ready: pop, clear the watchdog, go to WAIT.
    - pcr_req_valid stays high, and the head stays stable, until the request fires.
  - WAIT: the watchdog increments each cycle.
    - If pcr_resp_valid: capture pcr_resp_data into host_resp_data, set timeout = 0, go to RESP.
    - Else, if TIMEOUT_CYCLES != 0 and watchdog == TIMEOUT_CYCLES-1: set host_resp_data = 0, timeout = 1, go to RESP.
    - If pcr_resp_valid and the watchdog limit coincide, the real response wins.
  - RESP: host_resp_valid = 1, outputs held stable. On host_resp_ready, go to IDLE.
- Latency:
  - A command pushed at edge N into an idle, empty bridge gives pcr_req_valid high during cycle N+2.
  - A response captured at edge M gives host_resp_valid high during cycle M+1.
- pcr_resp_ready is constantly 1:
  - A pcr_resp_valid seen outside WAIT (a late response after a timeout) is discarded.
  - Each discard increments stale_drops, saturating at 255.
- Only one request is ever outstanding. The CSR file's req_ready is low until its own response drains, which keeps the bridge in lockstep.
- busy = (count != 0) || (state != IDLE).

Decomposition:
- Shared header vscale_htif_constants.vh holds:
  - the FSM state encodings (2-bit);
  - the command-entry width macro: 1 + `CSR_ADDR_WIDTH + `HTIF_PCR_WIDTH;
  - the default TIMEOUT_CYCLES.
- Existing widths come from vscale_ctrl_constants.vh and vscale_platform_constants.vh.
- One sub-module: vscale_htif_cmd_fifo. It is a parameterised synchronous FIFO with async active-low reset, a push/pop interface, and full/empty/count outputs.

Test Plan:
- Write 0x1234 to addr 0x780 with pcr_req_ready=1 and the response after 3 cycles -> pcr_req_valid high in cycle 2; host_resp_valid one cycle after pcr_resp_valid; timeout=0; host_resp_data equals the returned data.
- Push 5 commands back-to-back with CMD_DEPTH=4 and pcr_req_ready=0 -> host_cmd_ready drops after the 4th push; the 5th is held off. Requests issue in order with addrs intact; the 5th is accepted on the first pop.
- TIMEOUT_CYCLES=8, no pcr_resp_valid -> RESP reached 8 cycles after the request fire; host_resp_data=0, timeout=1. A later pcr_resp_valid in IDLE increments stale_drops to 1.
- pcr_resp_valid coincides with the watchdog limit -> timeout=0 and the real data is returned.
- host_resp_ready held 0 for 10 cycles -> host_resp_valid and data stay stable; no new pcr request is issued until the response is consumed.
- reset_n asserted in WAIT with 2 entries queued -> all outputs go to reset values immediately (async); after release, no response and no request appear until a new push.
